nn_dense_layer: RTL
===================

// Module: nn_dense_layer
// PURPOSE
// Fully-connected fixed-point layer stage with ReLU activation, sitting directly downstream of the network
// input channel. On req it reads the N_IN input samples through the channel's address/data read port.
// Per neuron it multiply-accumulates them against ROM weights plus bias, then saturates and applies ReLU.
// Results are registered on a_out; ack_layer raises when the layer completes.
// Chains with further instances via ack_layer -> req.
// PARAMETERS
// N_IN    2    number of input activations (read addresses 0..N_IN-1)
// N_OUT   2    number of neurons / output activations
// DW      8    signed data width of inputs, weights, biases, outputs
// FRAC    4    fractional bits (Q(DW-FRAC).FRAC); 1.0 == 1<<FRAC
// ACC_W   20   signed accumulator width; must be >= 2*DW+clog2(N_IN+1)
// W_INIT  0    packed N_OUT*N_IN*DW weights, neuron j input i at [(j*N_IN+i)*DW +: DW]
// B_INIT  0    packed N_OUT*DW biases, neuron j at [j*DW +: DW]
// PORTS
// clk        in   1            clock
// rst        in   1            reset
// req        in   1            start level from upstream (input channel filled)
// in_trig    out  1            read strobe to input channel, 1 cycle per address
// in_addr    out  clog2(N_IN)  read address to input channel
// in_data    in   DW signed    read data, valid the cycle after in_trig
// a_out      out  N_OUT*DW     output activations, neuron j at [j*DW +: DW], registered
// ack_layer  out  1            layer done; level, held until req falls
// BEHAVIOUR
// - Reset: rst is synchronous, active-high; clock is clk. Outputs under reset: a_out=0, ack_layer=0,
//   in_trig=0, in_addr=0. Internal state under reset: FSM=IDLE, acc=0, j=0, i=0.
// - Reset mid-operation aborts immediately; no partial a_out update survives.
// - FSM states: IDLE, BIAS, MAC, ACT, DONE.
//   IDLE->BIAS: req=1 && ack_layer=0.
//   BIAS: acc <= sext(bias[j])<<<FRAC; drive in_trig=1, in_addr=0; i<=0.
//   MAC: one cycle per input. acc += in_data*w[j][i], a signed DWxDW product sign-extended to ACC_W.
//     While i<N_IN-1, in_trig=1 and in_addr=i+1 are issued in the same cycle. After i==N_IN-1 -> ACT.
//   ACT: y = acc>>>FRAC, arithmetic shift. Saturate y to [-(2^(DW-1)), 2^(DW-1)-1]. ReLU: y<0 -> 0.
//     a_out[j] <= y. If j==N_OUT-1 -> DONE, else j++ and -> BIAS.
//   DONE: ack_layer=1; stays until req==0, then ack_layer<=0 next cycle, -> IDLE, j<=0.
// - Latency: ack_layer rises exactly 1+N_OUT*(N_IN+2) cycles after the IDLE cycle that samples req=1.
//   Default is 9 cycles.
// - req held high after DONE->IDLE does not restart; a new run needs req low for >=1 cycle then high.
// - req falling mid-computation is ignored; the run completes and ack_layer rises,
//   then drops the next cycle since req==0.
// - a_out holds its values from the last completed run until overwritten neuron by neuron in ACT.
// - in_trig is a single-cycle pulse per read; it is never asserted in IDLE/ACT/DONE.
// - All arithmetic is signed; accumulator overflow beyond ACC_W is excluded by the parameter constraint.
// STRUCTURE
// - Shared package nn_pkg: state enum nn_layer_state_t {IDLE,BIAS,MAC,ACT,DONE};
//   function sat_relu(acc, DW, FRAC); fixed-point constants ONE=1<<FRAC, DW default.
// - Sub-module nn_weight_rom: parameters W_INIT/B_INIT; combinational read of w[j][i] and bias[j]
//   by (j,i) index.
// - Main module: FSM, address counter i, neuron counter j, accumulator, output register file.
// TESTING (defaults N_IN=2,N_OUT=2,DW=8,FRAC=4; bench models channel memory with 1-cycle read)
// 1 mem={16,16}, w0={16,16}, b0=-16, w1={16,16}, b1=-32, pulse req high
//   -> ack_layer high at cycle 9, a_out={0,16} (neuron1=0, neuron0=16).
// 2 mem={127,127}, w0={127,127}, b0=0 -> neuron0 saturates to 127.
//   mem={-16,0}, w1={16,0}, b1=0 -> neuron1 = 0 (ReLU).
// 3 Handshake: keep req high 5 cycles after ack -> ack stays 1, no new in_trig.
//   Drop req -> ack 0 next cycle; re-raise -> new run, ack again after 9 cycles.
// 4 Assert rst at cycle 4 of a run -> next cycle a_out=0, ack=0, in_trig=0.
//   Release with req=1 -> full run, correct results at cycle 9.
// 5 Read protocol: check in_trig pulses at addresses 0,1 per neuron (4 pulses total).
//   Each pulse is followed by in_data being consumed the next cycle.
// 6 mem={-128,-128}, w0={-128,-128}, b0=-128
//   -> positive overflow saturates to 127; no wrap at ACC_W=20.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the dense-layer pipeline stages.
package nn_pkg;

  localparam int unsigned NN_DW   = 8;
  localparam int unsigned NN_FRAC = 4;
  localparam int          NN_ONE  = 1 << NN_FRAC;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    ACT,
    DONE
  } nn_layer_state_t;

  // Rescale an accumulator back to Q(dw-frac).frac, clamp to the positive
  // output range and apply ReLU. Only the low dw bits of the result matter.
  function automatic logic signed [31:0] sat_relu(input logic signed [31:0] acc,
                                                  input int unsigned dw,
                                                  input int unsigned frac);
    logic signed [31:0] y;
    logic signed [31:0] y_max;
    y     = acc >>> frac;
    y_max = (32'sd1 <<< (dw - 1)) - 32'sd1;
    if (y < 32'sd0) begin
      sat_relu = '0;
    end else if (y > y_max) begin
      sat_relu = y_max;
    end else begin
      sat_relu = y;
    end
  endfunction

endpackage

// File: rtl/nn_weight_rom.sv
// Constant weight/bias table for one dense layer, read combinationally by (neuron, input).
module nn_weight_rom
  import nn_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned DW    = NN_DW,
  parameter logic [N_OUT*N_IN*DW-1:0] W_INIT = '0,
  parameter logic [N_OUT*DW-1:0]      B_INIT = '0,
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic        [JW-1:0]            j,
  input  logic        [$clog2(N_IN)-1:0]  i,
  output logic signed [DW-1:0]            w,
  output logic signed [DW-1:0]            b
);

  logic signed [DW-1:0] w_tab [N_OUT][N_IN];
  logic signed [DW-1:0] b_tab [N_OUT];

  for (genvar jj = 0; jj < N_OUT; jj++) begin : g_neuron
    assign b_tab[jj] = B_INIT[jj*DW +: DW];
    for (genvar ii = 0; ii < N_IN; ii++) begin : g_input
      assign w_tab[jj][ii] = W_INIT[(jj*N_IN+ii)*DW +: DW];
    end
  end

  // Table lookup for the currently selected neuron and input.
  always_comb begin
    w = w_tab[j][i];
    b = b_tab[j];
  end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected fixed-point layer with ReLU: reads inputs from the upstream
// channel one address per cycle, MACs them per neuron, and raises ack_layer when done.
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned DW    = NN_DW,
  parameter int unsigned FRAC  = NN_FRAC,
  parameter int unsigned ACC_W = 20,
  parameter logic [N_OUT*N_IN*DW-1:0] W_INIT = '0,
  parameter logic [N_OUT*DW-1:0]      B_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     in_trig,
  output logic [$clog2(N_IN)-1:0]  in_addr,
  input  logic signed [DW-1:0]     in_data,
  output logic [N_OUT*DW-1:0]      a_out,
  output logic                     ack_layer
);

  localparam int unsigned AW = $clog2(N_IN);
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [AW-1:0] I_LAST = AW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  nn_layer_state_t state_q, state_d;
  logic [AW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_OUT*DW-1:0]     a_out_q, a_out_d;

  logic signed [DW-1:0]    w;
  logic signed [DW-1:0]    b;
  logic signed [2*DW-1:0]  prod;
  logic [DW-1:0]           y_act;

  nn_weight_rom #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .DW    (DW),
    .W_INIT(W_INIT),
    .B_INIT(B_INIT)
  ) u_rom (
    .j(j_q),
    .i(i_q),
    .w(w),
    .b(b)
  );

  assign a_out     = a_out_q;
  assign ack_layer = (state_q == DONE);

  // Datapath helpers: full-width signed product and the activated result of acc.
  always_comb begin
    prod  = in_data * w;
    y_act = DW'(sat_relu(32'(acc_q), DW, FRAC));
  end

  // Next-state, counters, accumulator and channel read strobes.
  // The read for input i+1 is issued while input i is being accumulated,
  // so each input costs exactly one MAC cycle.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    a_out_d = a_out_q;
    in_trig = 1'b0;
    in_addr = '0;
    case (state_q)
      IDLE: begin
        if (req && !ack_layer) begin
          state_d = BIAS;
        end
      end
      BIAS: begin
        acc_d   = ACC_W'(b) <<< FRAC;
        in_trig = 1'b1;
        in_addr = '0;
        i_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (i_q == I_LAST) begin
          state_d = ACT;
        end else begin
          in_trig = 1'b1;
          in_addr = i_q + 1'b1;
          i_d     = i_q + 1'b1;
        end
      end
      ACT: begin
        a_out_d[j_q*DW +: DW] = y_act;
        if (j_q == J_LAST) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = BIAS;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
          j_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      a_out_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      a_out_q <= a_out_d;
    end
  end

endmodule
